mul_share_arbiter: RTL and testbench

//   Shares one iterative shift-add multiplier between NUM_REQ requesters (pipeline execute stages or

---
 rtl/core_pkg.sv | 21 ++
 rtl/mul_shift_add.sv | 47 ++++
 rtl/mul_share_arbiter.sv | 149 ++++++++++++++
 tb/tb_mul_share_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared ALU opcodes, multiplier FSM states and default datapath widths.
// No logic; imported by the multiplier and its arbiter.
package core_pkg;

  localparam logic [7:0] ALU_MUL_REG = 8'h3;
  localparam logic [7:0] ALU_MUL_IMM = 8'h4;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_TAG_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  function automatic logic is_mul_op(input logic [7:0] op);
    return (op == ALU_MUL_REG) || (op == ALU_MUL_IMM);
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle after load, low WIDTH bits kept.
// Steps = max(1, bit-length(op2)); last_step stays high from the final step until the next load.
module mul_shift_add
  import core_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             load,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             last_step,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic             last_q;

  // last_q doubles as the run enable: stepping stops once the post-step multiplier is zero.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      last_q   <= 1'b1;
    end else if (load) begin
      mcand_q  <= op1;
      mplier_q <= op2;
      acc_q    <= '0;
      last_q   <= 1'b0;
    end else if (!last_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      last_q   <= ((mplier_q >> 1) == '0);
    end
  end

  assign last_step = last_q;
  assign product   = acc_q;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one shift-add multiplier; result valid k+1 edges after accept, k = max(1, bitlen(op2)).
// One op in flight: requesters wait (ready low) outside IDLE; result is held in DONE until resp_ready_i.
module mul_share_arbiter
  import core_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]       req_op1_i,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]       req_op2_i,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]   req_tag_i,
  output logic                                resp_valid_o,
  input  logic                                resp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]          resp_id_o,
  output logic [TAG_WIDTH-1:0]                resp_tag_o,
  output logic [WIDTH-1:0]                    resp_result_o,
  output logic                                busy_o
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef struct packed {
    logic [IDW-1:0]       id;
    logic [TAG_WIDTH-1:0] tag;
    logic [WIDTH-1:0]     result;
  } resp_t;

  mul_state_e           state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q;
  logic [IDW-1:0]       owner_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 post_rst_q;
  logic [IDW-1:0]       grant_idx;
  logic                 grant_vld;
  logic                 load;
  logic                 last_step;
  logic [WIDTH-1:0]     product;
  resp_t                resp_q;
  logic                 resp_vld_q;
  logic                 resp_fire;

  // First pending requester at or after rr_ptr_q, wrapping.
  always_comb begin
    int             c;
    logic [IDW-1:0] cand;
    c         = 0;
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(rr_ptr_q) + i;
      if (c >= NUM_REQ) begin
        c = c - NUM_REQ;
      end
      cand = IDW'(c);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load)         state_d = BUSY;
      BUSY:    if (last_step)    state_d = DONE;
      DONE:    if (resp_ready_i) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Grants are held off for the first cycle after reset so every output reads zero then.
  always_comb begin
    req_ready_o = '0;
    load        = 1'b0;
    busy_o      = 1'b0;
    if (!reset_i) begin
      busy_o = (state_q != IDLE);
      if (state_q == IDLE && !post_rst_q && grant_vld) begin
        req_ready_o[grant_idx] = 1'b1;
        load                   = 1'b1;
      end
    end
  end

  assign resp_fire = (state_q == DONE) && resp_ready_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      tag_q      <= '0;
      post_rst_q <= 1'b1;
    end else begin
      post_rst_q <= 1'b0;
      if (load) begin
        owner_q <= grant_idx;
        tag_q   <= req_tag_i[grant_idx];
      end
      if (resp_fire) begin
        rr_ptr_q <= (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      resp_q     <= '0;
      resp_vld_q <= 1'b0;
    end else if (state_q == BUSY && last_step) begin
      resp_q     <= '{id: owner_q, tag: tag_q, result: product};
      resp_vld_q <= 1'b1;
    end else if (resp_fire) begin
      resp_vld_q <= 1'b0;
    end
  end

  mul_shift_add #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .load      (load),
    .op1       (req_op1_i[grant_idx]),
    .op2       (req_op2_i[grant_idx]),
    .last_step (last_step),
    .product   (product)
  );

  assign resp_valid_o  = resp_vld_q & ~reset_i;
  assign resp_id_o     = resp_q.id & {IDW{~reset_i}};
  assign resp_tag_o    = resp_q.tag & {TAG_WIDTH{~reset_i}};
  assign resp_result_o = resp_q.result & {WIDTH{~reset_i}};

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: directed cases, then randomized traffic vs. a behavioural model.
module tb_mul_share_arbiter;

  localparam int N   = 2;
  localparam int W   = 32;
  localparam int TW  = 8;
  localparam int IDW = 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [N-1:0]             req_valid = '0;
  logic [N-1:0]             req_ready;
  logic [N-1:0][W-1:0]      op1 = '0;
  logic [N-1:0][W-1:0]      op2 = '0;
  logic [N-1:0][TW-1:0]     tagv = '0;
  logic                     resp_ready = 1'b0;
  logic                     resp_valid;
  logic [IDW-1:0]           resp_id;
  logic [TW-1:0]            resp_tag;
  logic [W-1:0]             resp_result;
  logic                     busy;

  always #5 clk = ~clk;

  mul_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_op1_i     (op1),
    .req_op2_i     (op2),
    .req_tag_i     (tagv),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_id_o     (resp_id),
    .resp_tag_o    (resp_tag),
    .resp_result_o (resp_result),
    .busy_o        (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int bitlen_k(input logic [31:0] b);
    int k = 0;
    while (b != 0) begin
      k++;
      b = b >> 1;
    end
    return (k == 0) ? 1 : k;
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  typedef struct {
    int          id;
    logic [7:0]  tag;
    logic [31:0] res;
    int          acc_edge;
    int          k;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  bit   outstanding = 0;
  bit   was_valid   = 0;
  bit   post_rst    = 0;
  int   rr          = 0;
  exp_t held;

  // Monitor: samples at the falling edge, when inputs and outputs are settled.
  always @(negedge clk) begin : monitor
    logic [N-1:0] exp_rdy;
    bit           found;
    int           g;
    exp_t         e;
    if (rst) begin
      chk("reset_outputs", {resp_valid, resp_id, resp_tag, resp_result, busy, req_ready}, 64'd0);
      sb.delete();
      outstanding = 0;
      was_valid   = 0;
      rr          = 0;
      post_rst    = 1;
    end else begin
      if (post_rst)
        chk("post_reset_outputs", {resp_valid, resp_id, resp_tag, resp_result, busy, req_ready}, 64'd0);
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      chk("busy", busy, outstanding);
      exp_rdy = '0;
      found   = 0;
      if (!outstanding && !post_rst) begin
        for (int i = 0; i < N; i++) begin
          g = (rr + i) % N;
          if (!found && req_valid[g]) begin
            found   = 1;
            exp_rdy = N'(1) << g;
          end
        end
      end
      chk("grant", req_ready, exp_rdy);
      if (|(req_valid & req_ready)) begin
        g          = req_ready[1] ? 1 : 0;
        e.id       = g;
        e.tag      = tagv[g];
        e.res      = ref_mul(op1[g], op2[g]);
        e.acc_edge = cyc + 1;
        e.k        = bitlen_k(op2[g]);
        sb.push_back(e);
        grant_log.push_back(g);
        outstanding = 1;
      end
      if (resp_valid) begin
        if (!was_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_response: got tag %0h result %0h, expected no response", resp_tag, resp_result);
            held.id  = int'(resp_id);
            held.tag = resp_tag;
            held.res = resp_result;
          end else begin
            held = sb.pop_front();
            chk("resp_result", resp_result, held.res);
            chk("resp_tag", resp_tag, held.tag);
            chk("resp_id", resp_id, held.id);
            chk("resp_latency", cyc, held.acc_edge + held.k + 1);
          end
        end else begin
          chk("hold_result", resp_result, held.res);
          chk("hold_tag", resp_tag, held.tag);
          chk("hold_id", resp_id, held.id);
        end
        if (resp_ready) begin
          outstanding = 0;
          rr          = (held.id + 1) % N;
          was_valid   = 0;
        end else begin
          was_valid = 1;
        end
      end else begin
        was_valid = 0;
      end
      post_rst = 0;
    end
  end

  // Call at posedge+2; returns at posedge+2 just after the accept edge with valid dropped.
  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
    int n = 0;
    op1[r]       = a;
    op2[r]       = b;
    tagv[r]      = t;
    req_valid[r] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[r] && n < 600);
    if (!req_ready[r]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: requester %0d got no ready in %0d cycles, expected a grant", r, n);
    end
    @(posedge clk);
    #2;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((outstanding || sb.size() != 0) && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (outstanding || sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d responses pending, expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op2();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return $urandom;
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  exp_order[4];
    int  n;
    bit  done0;
    bit  done1;
    exp_order = '{0, 1, 0, 1};
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Basic product, then truncation and zero multiplier.
    resp_ready = 1'b1;
    issue(0, 32'd6, 32'd7, 8'h03);
    wait_idle();
    issue(1, 32'hFFFF_FFFF, 32'd2, 8'h11);
    wait_idle();
    issue(1, 32'd5, 32'd0, 8'h12);
    wait_idle();

    // Continuous contention alternates grants.
    do_reset();
    grant_log.delete();
    fork
      begin
        issue(0, 32'd10, 32'd1, 8'h40);
        issue(0, 32'd11, 32'd1, 8'h41);
      end
      begin
        issue(1, 32'd20, 32'd1, 8'h50);
        issue(1, 32'd21, 32'd1, 8'h51);
      end
    join
    wait_idle();
    chk("rr_log_size", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk($sformatf("rr_order_%0d", i), grant_log[i], exp_order[i]);

    // Response backpressure holds DONE and blocks the waiting requester.
    resp_ready = 1'b0;
    issue(0, 32'd9, 32'd9, 8'h21);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("bp_resp_seen", resp_valid, 1);
    fork
      issue(1, 32'd4, 32'd4, 8'h22);
    join_none
    repeat (5) @(negedge clk);
    chk("bp_busy", busy, 1);
    chk("bp_no_accept", req_ready[1], 0);
    @(posedge clk);
    #2;
    resp_ready = 1'b1;
    wait fork;
    wait_idle();
    chk("bp_then_req1", grant_log[grant_log.size()-1], 1);

    // Reset mid-operation aborts it; arbitration restarts at requester 0.
    issue(1, 32'd3, 32'h8000_0000, 8'h31);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    grant_log.delete();
    fork
      issue(1, 32'd7, 32'd3, 8'h32);
      issue(0, 32'd2, 32'd5, 8'h33);
    join
    wait_idle();
    chk("post_reset_first_grant", grant_log[0], 0);

    // Randomized traffic with random response backpressure.
    do_reset();
    done0 = 0;
    done1 = 0;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #2;
          end
          issue(0, $urandom, rnd_op2(), 8'($urandom));
        end
        done0 = 1;
      end
      begin
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #2;
          end
          issue(1, $urandom, rnd_op2(), 8'($urandom));
        end
        done1 = 1;
      end
      begin
        while (!(done0 && done1)) begin
          @(posedge clk);
          #2;
          resp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    resp_ready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);
    chk("drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
